// File: rtl/cam2npu_pkg.sv
// cam2npu_pkg: shared types and constants for the camera-to-NPU image writer.
package cam2npu_pkg;

   // Capture controller states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // BT.601-style luma weights scaled by 256 (sum = 256)
   localparam logic [7:0] COEF_R = 8'd77;
   localparam logic [7:0] COEF_G = 8'd150;
   localparam logic [7:0] COEF_B = 8'd29;

   // RGB565 field positions
   localparam int R_HI = 15;
   localparam int R_LO = 11;
   localparam int G_HI = 10;
   localparam int G_LO = 5;
   localparam int B_HI = 4;
   localparam int B_LO = 0;

   // Widen a 5-bit channel to 8 bits by replicating its MSBs
   function automatic logic [7:0] expand5(input logic [4:0] v);
      return {v, v[4:2]};
   endfunction

   // Widen a 6-bit channel to 8 bits by replicating its MSBs
   function automatic logic [7:0] expand6(input logic [5:0] v);
      return {v, v[5:4]};
   endfunction

endpackage

// File: rtl/cam2npu_img_writer_rgb565_to_luma.sv
// rgb565_to_luma: two-stage pipelined RGB565 -> 8-bit luma converter with valid passthrough.
// Build macro CAM2NPU_INT8_EN: when defined the output byte is Y XOR 8'h80 (signed int8 Y-128).
module rgb565_to_luma
   import cam2npu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [15:0] in_pix,
   output logic        out_valid,
   output logic [7:0]  out_y
);

   logic [7:0]  r8_s;
   logic [7:0]  g8_s;
   logic [7:0]  b8_s;
   logic [15:0] prod_r_s;
   logic [15:0] prod_g_s;
   logic [15:0] prod_b_s;
   logic [15:0] prod_r_r;
   logic [15:0] prod_g_r;
   logic [15:0] prod_b_r;
   logic        valid1_r;
   logic [15:0] sum_s;
   logic [7:0]  y_s;

   // Channel expansion and weighted products (feeds stage 1)
   always_comb begin
      r8_s     = expand5(in_pix[R_HI:R_LO]);
      g8_s     = expand6(in_pix[G_HI:G_LO]);
      b8_s     = expand5(in_pix[B_HI:B_LO]);
      prod_r_s = {8'd0, COEF_R} * {8'd0, r8_s};
      prod_g_s = {8'd0, COEF_G} * {8'd0, g8_s};
      prod_b_s = {8'd0, COEF_B} * {8'd0, b8_s};
   end

   // Stage 1: register the three products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_r_r <= 16'd0;
         prod_g_r <= 16'd0;
         prod_b_r <= 16'd0;
         valid1_r <= 1'b0;
      end else if (flush) begin
         valid1_r <= 1'b0;
      end else begin
         valid1_r <= in_valid;
         if (in_valid) begin
            prod_r_r <= prod_r_s;
            prod_g_r <= prod_g_s;
            prod_b_r <= prod_b_s;
         end
      end
   end

   // Sum fits in 16 bits (max 65280); luma is the upper byte
   always_comb begin
      sum_s = prod_r_r + prod_g_r + prod_b_r;
`ifdef CAM2NPU_INT8_EN
      y_s   = sum_s[15:8] ^ 8'h80;
`else
      y_s   = sum_s[15:8];
`endif
   end

   // Stage 2: register the luma byte; data holds when no pixel is present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_y     <= 8'd0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= valid1_r;
         if (valid1_r) begin
            out_y <= y_s;
         end
      end
   end

endmodule

// File: rtl/cam2npu_img_writer.sv
// cam2npu_img_writer: crops and decimates one camera frame per request and writes luma bytes
// sequentially into the NPU image buffer.
// Build macro CAM2NPU_INT8_EN (applied inside rgb565_to_luma) selects signed int8 output bytes.
module cam2npu_img_writer
   import cam2npu_pkg::*;
#(
   parameter int SRC_W   = 640,
   parameter int SRC_H   = 480,
   parameter int CROP_X0 = 128,
   parameter int CROP_Y0 = 48,
   parameter int STEP    = 4,
   parameter int OUT_W   = 96,
   parameter int OUT_H   = 96,
   parameter int ADDR_W  = 14
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic              pix_valid,
   input  logic [15:0]       pix_data,
   input  logic              frame_req,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_err,
   output logic              buf_cea,
   output logic [ADDR_W-1:0] buf_ada,
   output logic [7:0]        buf_din
);

   localparam int X_W  = $clog2(SRC_W);
   localparam int Y_W  = $clog2(SRC_H);
   localparam int XE_W = X_W + 1;
   localparam int YE_W = Y_W + 1;

   // Window bounds carry one extra bit so an end bound equal to the line length still fits
   localparam logic [XE_W-1:0]   X_LO      = XE_W'(CROP_X0);
   localparam logic [XE_W-1:0]   X_HI      = XE_W'(CROP_X0 + OUT_W * STEP);
   localparam logic [YE_W-1:0]   Y_LO      = YE_W'(CROP_Y0);
   localparam logic [YE_W-1:0]   Y_HI      = YE_W'(CROP_Y0 + OUT_H * STEP);
   localparam logic [XE_W-1:0]   X_MASK    = XE_W'(STEP - 1);
   localparam logic [YE_W-1:0]   Y_MASK    = YE_W'(STEP - 1);
   localparam logic [X_W-1:0]    X_MAX     = X_W'(SRC_W - 1);
   localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(SRC_H - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(OUT_W * OUT_H - 1);

   state_t            state_r;
   state_t            state_next_s;
   logic              vsync_d_r;
   logic              href_d_r;
   logic [X_W-1:0]    src_x_r;
   logic [Y_W-1:0]    src_y_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic              vsync_rise_s;
   logic              href_fall_s;
   logic              pix_acc_s;
   logic [XE_W-1:0]   x_ext_s;
   logic [YE_W-1:0]   y_ext_s;
   logic [XE_W-1:0]   dx_s;
   logic [YE_W-1:0]   dy_s;
   logic              keep_s;
   logic              clear_s;
   logic              err_s;
   logic              last_write_s;

   // Edge detection; a pixel on the href falling-edge cycle still belongs to the ending line
   always_comb begin
      vsync_rise_s = cam_vsync & ~vsync_d_r;
      href_fall_s  = href_d_r & ~cam_href;
      pix_acc_s    = pix_valid & (cam_href | href_fall_s);
   end

   // Crop window and decimation phase test on the pre-increment source coordinates
   always_comb begin
      x_ext_s = {1'b0, src_x_r};
      y_ext_s = {1'b0, src_y_r};
      dx_s    = x_ext_s - X_LO;
      dy_s    = y_ext_s - Y_LO;
      keep_s  = (state_r == CAPTURE) && pix_acc_s && !vsync_rise_s &&
                (x_ext_s >= X_LO) && (x_ext_s < X_HI) &&
                (y_ext_s >= Y_LO) && (y_ext_s < Y_HI) &&
                ((dx_s & X_MASK) == {XE_W{1'b0}}) &&
                ((dy_s & Y_MASK) == {YE_W{1'b0}});
   end

   // Next-state logic, final-write detection and short-frame detection
   always_comb begin
      state_next_s = state_r;
      last_write_s = 1'b0;
      err_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (frame_req) state_next_s = ARM;
            else           state_next_s = IDLE;
         end
         ARM: begin
            if (vsync_rise_s) state_next_s = CAPTURE;
            else              state_next_s = ARM;
         end
         CAPTURE: begin
            if (buf_cea && (wr_addr_r == LAST_ADDR)) begin
               last_write_s = 1'b1;
               state_next_s = DONE;
            end else if (vsync_rise_s) begin
               err_s        = 1'b1;
               state_next_s = CAPTURE;
            end else begin
               state_next_s = CAPTURE;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
      clear_s = ((state_r == ARM) && vsync_rise_s) || err_s;
   end

   // State register, sync-edge history and registered status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         vsync_d_r  <= 1'b0;
         href_d_r   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         vsync_d_r  <= cam_vsync;
         href_d_r   <= cam_href;
         busy       <= (state_next_s == ARM) || (state_next_s == CAPTURE);
         frame_done <= (state_next_s == DONE);
         frame_err  <= err_s;
      end
   end

   // Source position counters; saturate instead of wrapping on oversized frames
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_x_r <= {X_W{1'b0}};
         src_y_r <= {Y_W{1'b0}};
      end else if (clear_s) begin
         src_x_r <= {X_W{1'b0}};
         src_y_r <= {Y_W{1'b0}};
      end else if (state_r == CAPTURE) begin
         if (href_fall_s) begin
            src_x_r <= {X_W{1'b0}};
            if (src_y_r != Y_MAX) src_y_r <= src_y_r + {{(Y_W-1){1'b0}}, 1'b1};
         end else if (pix_acc_s && (src_x_r != X_MAX)) begin
            src_x_r <= src_x_r + {{(X_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Buffer write address: advances after each write, never past the last byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_r <= {ADDR_W{1'b0}};
      end else if (clear_s || (state_r == DONE)) begin
         wr_addr_r <= {ADDR_W{1'b0}};
      end else if ((state_r == CAPTURE) && buf_cea && !last_write_s) begin
         wr_addr_r <= wr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
   end

   rgb565_to_luma u_luma (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (err_s),
      .in_valid  (keep_s),
      .in_pix    (pix_data),
      .out_valid (buf_cea),
      .out_y     (buf_din)
   );

   assign buf_ada = wr_addr_r;

endmodule

// File: tb/tb_cam2npu_img_writer.sv
// tb_cam2npu_img_writer: scoreboard bench for cam2npu_img_writer on a reduced frame geometry.
module tb_cam2npu_img_writer;

   localparam int SRC_W   = 64;
   localparam int SRC_H   = 40;
   localparam int CROP_X0 = 16;
   localparam int CROP_Y0 = 8;
   localparam int STEP    = 4;
   localparam int OUT_W   = 8;
   localparam int OUT_H   = 6;
   localparam int ADDR_W  = 14;
   localparam int N_PIX   = OUT_W * OUT_H;

   typedef struct packed {
      int                cyc;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              cam_vsync = 1'b0;
   logic              cam_href = 1'b0;
   logic              pix_valid = 1'b0;
   logic [15:0]       pix_data = 16'd0;
   logic              frame_req = 1'b0;
   logic              busy;
   logic              frame_done;
   logic              frame_err;
   logic              buf_cea;
   logic [ADDR_W-1:0] buf_ada;
   logic [7:0]        buf_din;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          write_cnt = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          cyc = 0;
   int          exp_addr = 0;
   int          last_addr = 0;
   logic [7:0]  last_din = 8'd0;
   logic [15:0] const_pix = 16'd0;
   exp_t        exp_q[$];

   cam2npu_img_writer #(
      .SRC_W(SRC_W), .SRC_H(SRC_H), .CROP_X0(CROP_X0), .CROP_Y0(CROP_Y0),
      .STEP(STEP), .OUT_W(OUT_W), .OUT_H(OUT_H), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
      .pix_valid(pix_valid), .pix_data(pix_data), .frame_req(frame_req),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
      .buf_cea(buf_cea), .buf_ada(buf_ada), .buf_din(buf_din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic logic [7:0] adj(input int y);
`ifdef CAM2NPU_INT8_EN
      return 8'(y) ^ 8'h80;
`else
      return 8'(y);
`endif
   endfunction

   function automatic logic [7:0] exp_luma(input logic [15:0] p);
      int r, g, b;
      r = (p >> 11) & 31;
      g = (p >> 5) & 63;
      b = p & 31;
      r = (r << 3) | (r >> 2);
      g = (g << 2) | (g >> 4);
      b = (b << 3) | (b >> 2);
      return adj((77 * r + 150 * g + 29 * b) / 256);
   endfunction

   function automatic bit kept(input int x, input int y);
      return (x >= CROP_X0) && (x < CROP_X0 + OUT_W * STEP) &&
             (y >= CROP_Y0) && (y < CROP_Y0 + OUT_H * STEP) &&
             (((x - CROP_X0) % STEP) == 0) && (((y - CROP_Y0) % STEP) == 0);
   endfunction

   function automatic logic [15:0] make_pix(input int x, input int y, input int pattern);
      if (pattern == 1)      return 16'(x & 31);
      else if (pattern == 2) return 16'((x * 2477 + y * 40503 + 12345) & 16'hFFFF);
      else                   return const_pix;
   endfunction

   // Scoreboard: every buffer write must match the oldest expected entry, including its cycle
   always @(negedge clk) begin
      exp_t ent;
      if (rst_n) begin
         if (frame_done) done_cnt++;
         if (frame_err)  err_cnt++;
         if (buf_cea) begin
            write_cnt++;
            last_din  = buf_din;
            last_addr = int'(buf_ada);
            tests_run++;
            if (exp_q.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_write: addr=%0d din=%0d, required no write", buf_ada, buf_din);
            end else begin
               ent = exp_q.pop_front();
               if (buf_ada !== ent.addr || buf_din !== ent.data || cyc !== ent.cyc) begin
                  tests_failed++;
                  $display("FAIL write: addr=%0d din=%0d cyc=%0d, required addr=%0d din=%0d cyc=%0d",
                           buf_ada, buf_din, cyc, ent.addr, ent.data, ent.cyc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_req();
      frame_req = 1'b1;
      tick();
      frame_req = 1'b0;
   endtask

   // Drive one frame; optionally pulse frame_req or reset before a given line
   task automatic send_frame(input int nlines, input int pattern, input bit cap,
                             input int req_line, input int rst_line, input bit short_line);
      exp_t ent;
      bit   stop;
      int   xend;
      stop     = 1'b0;
      exp_addr = 0;
      xend     = short_line ? (CROP_X0 + (OUT_W - 1) * STEP) : (SRC_W - 1);
      cam_vsync = 1'b1; tick(); tick();
      cam_vsync = 1'b0; tick(); tick();
      for (int y = 0; y < nlines && !stop; y++) begin
         if (y == req_line) pulse_req();
         if (y == rst_line) begin
            tests_run++;
            if (busy !== 1'b1) begin
               tests_failed++;
               $display("FAIL busy_before_reset: got %0b, required 1", busy);
            end
            rst_n = 1'b0;
            #1;
            tests_run++;
            if ({busy, frame_done, frame_err, buf_cea, buf_ada, buf_din} !== {(ADDR_W + 12){1'b0}}) begin
               tests_failed++;
               $display("FAIL outputs_in_reset: busy=%0b cea=%0b ada=%0d din=%0d, required all 0",
                        busy, buf_cea, buf_ada, buf_din);
            end
            tick(); tick();
            rst_n = 1'b1;
            tick();
            stop = 1'b1;
         end else begin
            cam_href = 1'b1;
            for (int x = 0; x <= xend; x++) begin
               if ((x % 7) == 3) begin
                  pix_valid = 1'b0;
                  tick();
               end
               pix_valid = 1'b1;
               pix_data  = make_pix(x, y, pattern);
               if (short_line && x == xend) cam_href = 1'b0;
               if (cap && kept(x, y)) begin
                  ent.cyc  = cyc + 2;
                  ent.addr = ADDR_W'(exp_addr);
                  ent.data = exp_luma(pix_data);
                  exp_q.push_back(ent);
                  exp_addr++;
               end
               tick();
            end
            pix_valid = 1'b0;
            cam_href  = 1'b0;
            repeat (3) tick();
         end
      end
      repeat (4) tick();
   endtask

   task automatic test_reset();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      tests_run++;
      if ({busy, frame_done, frame_err, buf_cea} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got busy=%0b done=%0b err=%0b cea=%0b, required 0",
                  busy, frame_done, frame_err, buf_cea);
      end
      tests_run++;
      if (buf_ada !== {ADDR_W{1'b0}} || buf_din !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_bus: got ada=%0d din=%0d, required 0 0", buf_ada, buf_din);
      end
   endtask

   // Full frame capture and common end-of-frame checks
   task automatic run_capture(input string name, input int pattern, input bit short_line,
                              input int req_line);
      int w0, d0, e0;
      w0 = write_cnt; d0 = done_cnt; e0 = err_cnt;
      pulse_req();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s_busy_start: got %0b, required 1", name, busy);
      end
      send_frame(SRC_H, pattern, 1'b1, req_line, -1, short_line);
      tests_run++;
      if (write_cnt - w0 !== N_PIX || exp_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL %s_writes: got %0d writes (%0d pending), required %0d",
                  name, write_cnt - w0, exp_q.size(), N_PIX);
      end
      tests_run++;
      if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s_done: got done=%0d err=%0d busy=%0b, required 1 0 0",
                  name, done_cnt - d0, err_cnt - e0, busy);
      end
      tests_run++;
      if (last_addr !== N_PIX - 1) begin
         tests_failed++;
         $display("FAIL %s_last_addr: got %0d, required %0d", name, last_addr, N_PIX - 1);
      end
      exp_q.delete();
   endtask

   task automatic test_full_frame();
      const_pix = 16'hFFFF;
      run_capture("white", 0, 1'b0, 2);
      tests_run++;
      if (last_din !== adj(255)) begin
         tests_failed++;
         $display("FAIL white_data: got %0d, required %0d", last_din, adj(255));
      end
   endtask

   task automatic test_gradient();
      run_capture("gradient", 1, 1'b1, -1);
   endtask

   task automatic test_req_mid_frame();
      int w0;
      w0 = write_cnt;
      send_frame(SRC_H, 2, 1'b0, 10, -1, 1'b0);
      tests_run++;
      if (write_cnt - w0 !== 0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreq_partial: got writes=%0d busy=%0b, required 0 1", write_cnt - w0, busy);
      end
      w0 = write_cnt;
      send_frame(SRC_H, 2, 1'b1, -1, -1, 1'b0);
      tests_run++;
      if (write_cnt - w0 !== N_PIX || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreq_capture: got writes=%0d busy=%0b, required %0d 0", write_cnt - w0, busy, N_PIX);
      end
      exp_q.delete();
   endtask

   task automatic test_short_frame();
      int w0, d0, e0;
      w0 = write_cnt; d0 = done_cnt; e0 = err_cnt;
      pulse_req();
      send_frame(20, 2, 1'b1, -1, -1, 1'b0);
      tests_run++;
      if (write_cnt - w0 !== 3 * OUT_W || err_cnt - e0 !== 0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL short_partial: got writes=%0d err=%0d busy=%0b, required %0d 0 1",
                  write_cnt - w0, err_cnt - e0, busy, 3 * OUT_W);
      end
      send_frame(SRC_H, 2, 1'b1, -1, -1, 1'b0);
      tests_run++;
      if (err_cnt - e0 !== 1 || done_cnt - d0 !== 1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL short_retry: got err=%0d done=%0d busy=%0b, required 1 1 0",
                  err_cnt - e0, done_cnt - d0, busy);
      end
      tests_run++;
      if (write_cnt - w0 !== 3 * OUT_W + N_PIX || last_addr !== N_PIX - 1) begin
         tests_failed++;
         $display("FAIL short_writes: got writes=%0d last=%0d, required %0d %0d",
                  write_cnt - w0, last_addr, 3 * OUT_W + N_PIX, N_PIX - 1);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt;
      pulse_req();
      send_frame(SRC_H, 2, 1'b1, -1, 20, 1'b0);
      tests_run++;
      if (exp_q.size() !== 0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
         tests_failed++;
         $display("FAIL reset_mid: got pending=%0d done=%0d err=%0d, required 0 0 0",
                  exp_q.size(), done_cnt - d0, err_cnt - e0);
      end
      exp_q.delete();
      run_capture("after_reset", 2, 1'b0, -1);
   endtask

   task automatic test_colors();
      logic [15:0] cols[3] = '{16'hF800, 16'h07E0, 16'h001F};
      int          lum[3]  = '{76, 149, 28};
      for (int i = 0; i < 3; i++) begin
         const_pix = cols[i];
         run_capture("color", 0, 1'b0, -1);
         tests_run++;
         if (last_din !== adj(lum[i])) begin
            tests_failed++;
            $display("FAIL color_%0d: got %0d, required %0d", i, last_din, adj(lum[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_gradient();
      test_req_mid_frame();
      test_short_frame();
      test_reset_mid();
      test_colors();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
